// File: rtl/bs_sort_loader_if.sv
// bs_sort_loader_if: producer handshake, clear and read port of the sorted-table loader
// master: drives in_valid/in_data/clear/rd_addr; slave: drives in_ready/rd_data/count/full/sorted
interface bs_sort_loader_if #(parameter int ADDR_W = 5, parameter int DATA_W = 8);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              clear;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              sorted;
  modport master (output in_valid, in_data, clear, rd_addr, input in_ready, rd_data, count, full, sorted);
  modport slave (input in_valid, in_data, clear, rd_addr, output in_ready, rd_data, count, full, sorted);
endinterface

// File: rtl/bs_sort_loader.sv
// bs_sort_loader: insertion-sorted 32x8 table fill stage with a registered read port
// ports: clk, reset_n (sync, active-low), bus (slave): valid/ready insert, clear, rd_addr->rd_data, count/full/sorted
module bs_sort_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic reset_n,
  bs_sort_loader_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] v_q, v_d, rd_data_q, rd_data_d;
  logic [ADDR_W-1:0] p_q, p_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full, accept, move;
  assign full         = count_q == (ADDR_W+1)'(DEPTH);
  assign bus.in_ready = reset_n && state_q == IDLE && !full && !bus.clear;
  assign bus.sorted   = !reset_n || state_q == IDLE;
  assign bus.full     = full;
  assign bus.count    = count_q;
  assign bus.rd_data  = rd_data_q;
  assign accept       = bus.in_valid && bus.in_ready;
  // entry above the hole is strictly greater: shift it up, so equal values stay ahead of v
  assign move         = p_q != '0 && mem_q[p_q - 1'b1] > v_q;
  always_comb begin
    mem_d     = mem_q;
    state_d   = state_q;
    v_d       = v_q;
    p_d       = p_q;
    count_d   = count_q;
    rd_data_d = mem_q[bus.rd_addr];
    if (bus.clear) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = '1;
      count_d = '0;
      state_d = IDLE;
    end else if (state_q == SHIFT) begin
      mem_d[p_q] = move ? mem_q[p_q - 1'b1] : v_q;
      p_d        = move ? p_q - 1'b1 : p_q;
      count_d    = move ? count_q : count_q + 1'b1;
      state_d    = move ? SHIFT : IDLE;
    end else if (accept) begin
      v_d     = bus.in_data;
      p_d     = count_q[ADDR_W-1:0];
      state_d = SHIFT;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '1;
      state_q   <= IDLE;
      v_q       <= '0;
      p_q       <= '0;
      count_q   <= '0;
      rd_data_q <= '1;
    end else begin
      mem_q     <= mem_d;
      state_q   <= state_d;
      v_q       <= v_d;
      p_q       <= p_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end
endmodule

// File: tb/tb_bs_sort_loader.sv
// tb_bs_sort_loader: vectors, corner sequences and random inserts checked against a sorted-queue model
module tb_bs_sort_loader;
  logic clk = 0;
  logic reset_n = 0;
  int total = 0;
  int bad = 0;
  int mq[$];
  typedef struct { logic [7:0] d; int lat; int cnt; } vec_t;
  vec_t vt[5];
  always #5 clk = ~clk;
  bs_sort_loader_if #(.ADDR_W(5), .DATA_W(8)) bus ();
  bs_sort_loader #(.DEPTH(32), .ADDR_W(5), .DATA_W(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  function automatic int mdl_ins(input int v);
    int k = 0;
    foreach (mq[i]) if (mq[i] > v) k++;
    mq.insert(mq.size() - k, v);
    return k + 1;
  endfunction

  task automatic rd(input int a, output int val);
    bus.rd_addr = a[4:0];
    tick();
    val = int'(bus.rd_data);
  endtask

  task automatic read_all(input string nm);
    int val;
    for (int a = 0; a < 32; a++) begin
      rd(a, val);
      chk($sformatf("%s[%0d]", nm, a), val, a < mq.size() ? mq[a] : 255);
    end
  endtask

  task automatic ins(input logic [7:0] v, output int lat);
    bus.in_valid = 1;
    bus.in_data  = v;
    tick();
    chk("ready_in_shift", int'(bus.in_ready), 0);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.sorted && lat < 40);
    if (lat >= 40) chk("latency_timeout", lat, -1);
  endtask

  task automatic do_clear();
    bus.in_valid = 0;
    bus.clear = 1;
    #1;
    chk("ready_during_clear", int'(bus.in_ready), 0);
    tick();
    bus.clear = 0;
    mq.delete();
    chk("clear_count", int'(bus.count), 0);
    chk("clear_sorted", int'(bus.sorted), 1);
  endtask

  task automatic search(input int key, output int found, output int loc);
    int lo = 0, hi = 32, mid, val;
    while (lo < hi) begin
      mid = (lo + hi) / 2;
      rd(mid, val);
      if (val < key) lo = mid + 1; else hi = mid;
    end
    found = 0;
    loc = lo;
    if (lo < 32) begin
      rd(lo, val);
      found = int'(val == key);
    end
  endtask

  initial begin
    int lat, ef, el, f, l, v;
    bus.in_valid = 0;
    bus.in_data  = 0;
    bus.clear    = 0;
    bus.rd_addr  = 0;
    vt[0] = '{8'd50, 1, 1};
    vt[1] = '{8'd10, 2, 2};
    vt[2] = '{8'd30, 2, 3};
    vt[3] = '{8'd10, 3, 4};
    vt[4] = '{8'd255, 1, 5};
    tick();
    chk("rst_ready", int'(bus.in_ready), 0);
    chk("rst_sorted", int'(bus.sorted), 1);
    tick();
    reset_n = 1;
    #1;
    chk("post_rst_count", int'(bus.count), 0);
    chk("post_rst_ready", int'(bus.in_ready), 1);
    read_all("rst_tab");

    for (int i = 0; i < 5; i++) begin
      ins(vt[i].d, lat);
      void'(mdl_ins(int'(vt[i].d)));
      chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
      chk($sformatf("vec%0d_cnt", i), int'(bus.count), vt[i].cnt);
    end
    bus.in_valid = 0;
    read_all("vec_tab");

    do_clear();
    for (int i = 0; i < 32; i++) begin
      el = mdl_ins(200 - i);
      ins(8'(200 - i), lat);
      chk("desc_lat", lat, el);
    end
    bus.in_valid = 0;
    chk("desc_last_lat", lat, 32);
    chk("full_count", int'(bus.count), 32);
    chk("full_flag", int'(bus.full), 1);
    chk("full_ready", int'(bus.in_ready), 0);
    bus.in_valid = 1;
    bus.in_data  = 8'd5;
    tick();
    tick();
    tick();
    bus.in_valid = 0;
    chk("full_hold_count", int'(bus.count), 32);
    read_all("full_tab");

    do_clear();
    for (int i = 0; i < 5; i++) begin
      void'(mdl_ins(100 + 10 * i));
      ins(8'(100 + 10 * i), lat);
    end
    bus.in_data = 8'd50;
    tick();
    bus.in_valid = 0;
    tick();
    tick();
    bus.clear = 1;
    tick();
    bus.clear = 0;
    mq.delete();
    chk("abort_count", int'(bus.count), 0);
    chk("abort_sorted", int'(bus.sorted), 1);
    read_all("abort_tab");

    for (int i = 0; i < 7; i++) begin
      void'(mdl_ins(10 * (i + 1)));
      ins(8'(10 * (i + 1)), lat);
    end
    bus.in_data = 8'd5;
    tick();
    bus.in_valid = 0;
    chk("mid_count", int'(bus.count), 7);
    tick();
    reset_n = 0;
    #1;
    chk("rst_mid_ready", int'(bus.in_ready), 0);
    chk("rst_mid_sorted", int'(bus.sorted), 1);
    tick();
    reset_n = 1;
    mq.delete();
    #1;
    chk("rst_mid_count", int'(bus.count), 0);
    chk("rst_mid_ready_after", int'(bus.in_ready), 1);
    read_all("rst_mid_tab");

    foreach (mq[i]) mq.delete(i);
    for (int i = 0; i < 4; i++) begin
      v = i == 0 ? 0 : i == 3 ? 9 : 3;
      void'(mdl_ins(v));
      ins(8'(v), lat);
    end
    bus.in_valid = 0;
    for (int t = 0; t < 2; t++) begin
      v = t == 0 ? 9 : 4;
      ef = 0;
      el = 0;
      foreach (mq[i]) if (!ef && mq[i] == v) begin ef = 1; el = i; end
      search(v, f, l);
      chk($sformatf("found_%0d", v), f, ef);
      if (ef) chk($sformatf("loc_%0d", v), l, el);
    end

    do_clear();
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 99) < 3) do_clear();
      else if (mq.size() == 32) begin
        bus.in_valid = 1;
        bus.in_data = 8'($urandom);
        tick();
        tick();
        bus.in_valid = 0;
        chk("rand_full_hold", int'(bus.count), 32);
        read_all("rand_full_tab");
        do_clear();
      end else begin
        v = $urandom_range(0, 15) * 17;
        el = mdl_ins(v);
        ins(8'(v), lat);
        chk("rand_lat", lat, el);
        chk("rand_count", int'(bus.count), mq.size());
        if ($urandom_range(0, 1) == 0) bus.in_valid = 0;
      end
      if (it % 25 == 24) begin
        bus.in_valid = 0;
        read_all("rand_tab");
      end
    end
    bus.in_valid = 0;
    read_all("final_tab");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
